// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and limits for the bit-serial adder
package serial_adder_pkg;

  localparam int SA_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle for the bit-serial adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - combinational full-adder cell
module fa_cell (
  input  logic x0,
  input  logic x1,
  input  logic x2,
  output logic s,
  output logic c
);
  assign s = x0 ^ x1 ^ x2;
  assign c = (x0 & x1) | (x0 & x2) | (x1 & x2);
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder sequencing one full-adder cell
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > SA_MAX_WIDTH) begin : g_width_check
    $error("serial_adder: WIDTH out of range");
  end

  sa_state_t        state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_s;
  logic             fa_c;

  fa_cell u_fa (
    .x0 (a_sr[0]),
    .x1 (b_sr[0]),
    .x2 (carry),
    .s  (fa_s),
    .c  (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
          carry <= fa_c;
          // Result registers only move on the final bit so partial sums never leak out.
          if (cnt == LAST) begin
            state  <= DONE;
            sum_q  <= {fa_s, s_sr[WIDTH-1:1]};
            cout_q <= fa_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8 and 16
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  int total  = 0;
  int passed = 0;
  int done8_cnt  = 0;
  int done16_cnt = 0;
  int hold8  = 0;
  int hold16 = 0;
  logic [8:0]  exp8[$];
  logic [16:0] exp16[$];
  logic [8:0]  prev8;
  logic [16:0] prev16;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitors: pop on every done, flag any output movement outside done.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev8 = '0;
    end else begin
      if (bus8.done) begin
        done8_cnt++;
        if (exp8.size() == 0) chk("dut8 done without pending op", exp8.size(), 1);
        else chk("dut8 result", {bus8.cout, bus8.sum}, exp8.pop_front());
      end else if ({bus8.cout, bus8.sum} !== prev8) begin
        hold8++;
      end
      prev8 = {bus8.cout, bus8.sum};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev16 = '0;
    end else begin
      if (bus16.done) begin
        done16_cnt++;
        if (exp16.size() == 0) chk("dut16 done without pending op", exp16.size(), 1);
        else chk("dut16 result", {bus16.cout, bus16.sum}, exp16.pop_front());
      end else if ({bus16.cout, bus16.sum} !== prev16) begin
        hold16++;
      end
      prev16 = {bus16.cout, bus16.sum};
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] e);
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
    exp8.push_back(e);
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = ~a; bus8.b = a ^ b; bus8.cin = ~c;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic [16:0] e);
    bus16.a = a; bus16.b = b; bus16.cin = c; bus16.start = 1'b1;
    exp16.push_back(e);
    @(posedge clk); #1;
    bus16.start = 1'b0; bus16.a = ~a; bus16.b = a ^ b; bus16.cin = ~c;
  endtask

  task automatic lat8(input string tag);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk({tag, " busy phase"}, {bus8.busy, bus8.done}, 2'b10);
    end
    @(negedge clk);
    chk({tag, " done phase"}, {bus8.busy, bus8.done}, 2'b01);
  endtask

  task automatic wait_done8();
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = bus8.done;
    end
    if (!seen) chk("dut8 done timeout", bus8.done, 1);
  endtask

  task automatic wait_done16();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus16.done;
    end
    if (!seen) chk("dut16 done timeout", bus16.done, 1);
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic c; logic [8:0] e; } vec8_t;
  vec8_t dir8[6] = '{
    '{8'h0F, 8'h01, 1'b0, 9'h010},
    '{8'hFF, 8'h01, 1'b0, 9'h100},
    '{8'hFF, 8'hFF, 1'b1, 9'h1FF},
    '{8'h00, 8'h00, 1'b0, 9'h000},
    '{8'hA5, 8'h5A, 1'b1, 9'h100},
    '{8'h7F, 8'h01, 1'b0, 9'h080}
  };

  initial begin
    int d;
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;
    logic        rc;

    rst_n = 1'b0;
    bus8.start = 0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 0;
    bus16.start = 0; bus16.a = '0; bus16.b = '0; bus16.cin = 0;
    repeat (2) @(negedge clk);
    chk("reset dut8",  {bus8.busy, bus8.done, bus8.cout, bus8.sum}, '0);
    chk("reset dut16", {bus16.busy, bus16.done, bus16.cout, bus16.sum}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (dir8[i]) begin
      issue8(dir8[i].a, dir8[i].b, dir8[i].c, dir8[i].e);
      lat8($sformatf("dir8[%0d]", i));
      @(negedge clk);
      chk("idle after done", {bus8.busy, bus8.done}, 2'b00);
    end

    // start pulsed mid-SHIFT must be ignored
    d = done8_cnt;
    issue8(8'h12, 8'h34, 1'b0, 9'h046);
    @(negedge clk); @(negedge clk);
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_done8();
    repeat (12) @(negedge clk);
    chk("single done for ignored start", done8_cnt - d, 1);

    issue8(8'h3C, 8'h0F, 1'b1, 9'h04C);
    lat8("b2b first");
    issue8(8'h80, 8'h80, 1'b0, 9'h100);
    lat8("b2b second");

    // abort mid-operation
    issue8(8'hFE, 8'h01, 1'b0, 9'h0FF);
    @(negedge clk); @(negedge clk); @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", {bus8.busy, bus8.done, bus8.cout, bus8.sum}, '0);
    void'(exp8.pop_back());
    d = done8_cnt;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no done after abort", done8_cnt - d, 0);
    issue8(8'h01, 8'h01, 1'b0, 9'h002);
    lat8("after reset");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      issue8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 9'(rc));
      wait_done8();
    end

    @(negedge clk);
    issue16(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    wait_done16();
    issue16(16'h1234, 16'h4321, 1'b1, 17'h05556);
    wait_done16();
    for (int i = 0; i < 1000; i++) begin
      wa = 16'($urandom); wb = 16'($urandom); rc = 1'($urandom);
      issue16(wa, wb, rc, {1'b0, wa} + {1'b0, wb} + 17'(rc));
      wait_done16();
    end

    repeat (3) @(negedge clk);
    chk("dut8 pending ops",  exp8.size(), 0);
    chk("dut16 pending ops", exp16.size(), 0);
    chk("dut8 output hold",  hold8, 0);
    chk("dut16 output hold", hold16, 0);
    chk("dut16 done count",  done16_cnt, 1002);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
